// File: rtl/param_prefetch_fifo_if.sv
// Handshake bundle for param_prefetch_fifo; the error-statistic signals exist
// only when PREFETCH_FIFO_ERR_STAT_EN is defined.
interface param_prefetch_fifo_if #(
  parameter int DATA_W  = 73,
  parameter int DEPTH_W = 12
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_vld;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;
  logic [DEPTH_W:0]  level;
  logic              almost_full;
  logic              almost_empty;
`ifdef PREFETCH_FIFO_ERR_STAT_EN
  logic              ovf_sticky;
  logic              udf_sticky;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_vld, rd_data, rd_vld, level, almost_full, almost_empty,
           ovf_sticky, udf_sticky
  );
  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_vld, rd_data, rd_vld, level, almost_full, almost_empty,
           ovf_sticky, udf_sticky
  );
`else
  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_vld, rd_data, rd_vld, level, almost_full, almost_empty
  );
  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_vld, rd_data, rd_vld, level, almost_full, almost_empty
  );
`endif
endinterface

// File: rtl/param_prefetch_fifo.sv
// First-word-fall-through FIFO: inferred RAM whose registered read port acts as
// the prefetch stage. Define PREFETCH_FIFO_ERR_STAT_EN for sticky ovf/udf flags.
module param_prefetch_fifo #(
  parameter int DATA_W    = 73,
  parameter int DEPTH_W   = 12,
  parameter int AFULL_TH  = (1 << DEPTH_W) - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  param_prefetch_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_W;

  typedef logic [DEPTH_W-1:0] ptr_t;
  typedef logic [DEPTH_W:0]   cnt_t;

  localparam cnt_t DEPTH_LVL  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_LVL  = cnt_t'(AFULL_TH);
  localparam cnt_t AEMPTY_LVL = cnt_t'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];

  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  cnt_t              ram_cnt_q, ram_cnt_d;
  cnt_t              level_q, level_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q;
  logic              wr_vld_q;
  logic              afull_q;
  logic              aempty_q;

  logic wr_acc;
  logic pop;
  logic load;

  // Words in RAM are counted from registered state only, so a word becomes
  // readable the cycle after it is written and read/write never hit one address.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    wr_acc    = bus.wr_en & wr_vld_q;
    pop       = bus.rd_en & out_vld_q;
    load      = (ram_cnt_q != '0) & (~out_vld_q | pop);
    wr_ptr_d  = wr_ptr_q + ptr_t'(wr_acc);
    rd_ptr_d  = rd_ptr_q + ptr_t'(load);
    ram_cnt_d = ram_cnt_q + cnt_t'(wr_acc) - cnt_t'(load);
    level_d   = level_q + cnt_t'(wr_acc) - cnt_t'(pop);
    out_vld_d = load | (out_vld_q & ~pop);
    if (bus.flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
      level_d   = '0;
      out_vld_d = 1'b0;
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable once the
  // pointers and counts are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc && !bus.flush) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so all registers sample together.
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      level_q    <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      wr_vld_q   <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      level_q   <= level_d;
      out_vld_q <= out_vld_d;
      wr_vld_q  <= (level_d < DEPTH_LVL);
      afull_q   <= (level_d >= AFULL_LVL);
      aempty_q  <= (level_d <= AEMPTY_LVL);
      if (load && !bus.flush) begin
        out_data_q <= mem[rd_ptr_q];
      end
    end
  end

`ifdef PREFETCH_FIFO_ERR_STAT_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr_en && !wr_vld_q)  ovf_q <= 1'b1;
      if (bus.rd_en && !out_vld_q) udf_q <= 1'b1;
    end
  end

  assign bus.ovf_sticky = ovf_q;
  assign bus.udf_sticky = udf_q;
`endif

  assign bus.wr_vld       = wr_vld_q;
  assign bus.rd_data      = out_data_q;
  assign bus.rd_vld       = out_vld_q;
  assign bus.level        = level_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;

endmodule

// File: tb/tb_param_prefetch_fifo.sv
// Directed bench for param_prefetch_fifo (DEPTH_W=4, DATA_W=12); sticky-flag
// checks are compiled when PREFETCH_FIFO_ERR_STAT_EN is defined.
module tb_param_prefetch_fifo;

  localparam int DW = 12;
  localparam int AW = 4;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  int   fail_cnt;

  logic [DW-1:0] q[$];
  logic [DW-1:0] next_val;
  logic          acc;
  logic          popd;

  param_prefetch_fifo_if #(.DATA_W(DW), .DEPTH_W(AW)) bus_if ();

  param_prefetch_fifo #(.DATA_W(DW), .DEPTH_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"},  bus_if.level, 0);
    check({tag, "_rd_vld"}, bus_if.rd_vld, 0);
    check({tag, "_wr_vld"}, bus_if.wr_vld, 0);
    check({tag, "_afull"},  bus_if.almost_full, 0);
    check({tag, "_aempty"}, bus_if.almost_empty, 1);
    check({tag, "_rd_data"}, bus_if.rd_data, 0);
`ifdef PREFETCH_FIFO_ERR_STAT_EN
    check({tag, "_ovf"}, bus_if.ovf_sticky, 0);
    check({tag, "_udf"}, bus_if.udf_sticky, 0);
`endif
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; fail_cnt = 0;
    rst_n = 1'b0;
    bus_if.flush = 1'b0; bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0; bus_if.wr_data = '0;

    // Reset state, then wr_vld rises on the first edge after release.
    repeat (3) step();
    check_reset_vals("rst");
    rst_n = 1'b1;
    step();
    check("wr_vld_after_rst", bus_if.wr_vld, 1);

    // Single word latency: write at cycle 0, level at 1, data at 2.
    bus_if.wr_en = 1'b1; bus_if.wr_data = 12'h001;
    step();
    bus_if.wr_en = 1'b0;
    check("lat_level_c1", bus_if.level, 1);
    check("lat_rd_vld_c1", bus_if.rd_vld, 0);
    step();
    check("lat_rd_vld_c2", bus_if.rd_vld, 1);
    check("lat_rd_data_c2", bus_if.rd_data, 12'h001);
    bus_if.rd_en = 1'b1;
    step();
    bus_if.rd_en = 1'b0;
    check("pop_rd_vld", bus_if.rd_vld, 0);
    check("pop_level", bus_if.level, 0);

    // Fill all 16 words and watch flags follow the level.
    for (int i = 1; i <= 16; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = 12'(16'h10 + i - 1);
      q.push_back(12'(16'h10 + i - 1));
      step();
      check("fill_level", bus_if.level, 64'(i));
      check("fill_afull", bus_if.almost_full, 64'(i >= 12));
      check("fill_aempty", bus_if.almost_empty, 64'(i <= 4));
      check("fill_wr_vld", bus_if.wr_vld, 64'(i < 16));
    end
    bus_if.wr_data = 12'h0AA;
    repeat (2) begin
      step();
      check("ovf_level", bus_if.level, 16);
      check("ovf_wr_vld", bus_if.wr_vld, 0);
      check("ovf_head_stable", bus_if.rd_data, 12'h010);
    end
    bus_if.wr_en = 1'b0;
`ifdef PREFETCH_FIFO_ERR_STAT_EN
    check("ovf_sticky", bus_if.ovf_sticky, 1);
`endif

    // Full throughput across pointer wrap: read and write held for 40 cycles.
    next_val = 12'h100;
    for (int i = 0; i < 40; i++) begin
      bus_if.rd_en = 1'b1; bus_if.wr_en = 1'b1; bus_if.wr_data = next_val;
      acc  = bus_if.wr_vld;
      popd = bus_if.rd_vld;
      check("thr_rd_vld", popd, 1);
      if (popd) check("thr_order", bus_if.rd_data, q[0]);
      step();
      if (acc) begin
        q.push_back(next_val);
        next_val = next_val + 12'h001;
      end
      if (popd) void'(q.pop_front());
      check("thr_level_range", (bus_if.level >= 15) && (bus_if.level <= 16), 1);
    end
    bus_if.wr_en = 1'b0;
    check("thr_level_end", bus_if.level, 15);

    // Drain to half full.
    for (int i = 0; i < 7; i++) begin
      check("drain_order", bus_if.rd_data, q[0]);
      step();
      void'(q.pop_front());
    end
    bus_if.rd_en = 1'b0;
    check("half_level", bus_if.level, 8);
    check("half_head", bus_if.rd_data, q[0]);

    // Flush beats a simultaneous write and pop.
    bus_if.flush = 1'b1; bus_if.wr_en = 1'b1; bus_if.rd_en = 1'b1; bus_if.wr_data = 12'h055;
    step();
    bus_if.flush = 1'b0; bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0;
    q.delete();
    check("flush_level", bus_if.level, 0);
    check("flush_rd_vld", bus_if.rd_vld, 0);
    check("flush_wr_vld", bus_if.wr_vld, 1);
    check("flush_aempty", bus_if.almost_empty, 1);
`ifdef PREFETCH_FIFO_ERR_STAT_EN
    check("flush_ovf", bus_if.ovf_sticky, 0);
    check("flush_udf", bus_if.udf_sticky, 0);
`endif
    repeat (2) step();
    check("flush_no_store", bus_if.rd_vld, 0);

    // Pops on an empty FIFO are ignored.
    bus_if.rd_en = 1'b1;
    repeat (3) begin
      step();
      check("udf_level", bus_if.level, 0);
      check("udf_rd_vld", bus_if.rd_vld, 0);
    end
    bus_if.rd_en = 1'b0;
`ifdef PREFETCH_FIFO_ERR_STAT_EN
    check("udf_sticky", bus_if.udf_sticky, 1);
`endif

    // Store 8 words, then assert reset asynchronously mid-cycle.
    for (int i = 0; i < 8; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = 12'(16'h30 + i);
      step();
    end
    bus_if.wr_en = 1'b0;
    check("pre_rst_level", bus_if.level, 8);
    check("pre_rst_head", bus_if.rd_data, 12'h030);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    rst_n = 1'b1;
    step();
    check("rerst_wr_vld", bus_if.wr_vld, 1);
    check("rerst_rd_vld", bus_if.rd_vld, 0);

    // Fresh data after reset, not stale RAM contents.
    bus_if.wr_en = 1'b1; bus_if.wr_data = 12'h077;
    step();
    bus_if.wr_en = 1'b0;
    check("post_rst_level", bus_if.level, 1);
    step();
    check("post_rst_rd_vld", bus_if.rd_vld, 1);
    check("post_rst_rd_data", bus_if.rd_data, 12'h077);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
